superscalar_free_list: RTL
==========================

# superscalar_free_list

Parametrised multi-port physical-register free list for the rename stage. Hands out up to ALLOC_W physical register IDs per cycle to rename and accepts up to FREE_W released IDs per cycle from commit. Branch recovery restores only the read pointer: frees are never speculative, so no list snapshot is needed. Sits between rename (allocate), ROB commit (free) and the branch checkpoint table (snapshot/restore).

## Interface
- NUM_PREGS, 128, physical registers; power of two, ≥ 2*NUM_AREGS
- NUM_AREGS, 32, architectural registers; p0..p(NUM_AREGS-1) are mapped at reset and never initially free
- ALLOC_W, 2, allocation lanes per cycle
- FREE_W, 2, free lanes per cycle
- PREG_W = $clog2(NUM_PREGS); PTR_W = PREG_W+1 (wrap bit), derived
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low (reset==0 resets on next edge)
- alloc_valid  in  1  rename requests alloc_num registers this cycle
- alloc_num  in  $clog2(ALLOC_W+1)  registers requested, 0..ALLOC_W
- alloc_ready  out  1  free_count ≥ alloc_num
- alloc_preg  out  ALLOC_W×PREG_W  lane i = list[r_ptr+i]; valid for i < alloc_num
- free_valid  in  FREE_W  per-lane free strobe, any bit pattern
- free_preg  in  FREE_W×PREG_W  IDs being released
- restore_valid  in  1  mispredict recovery
- restore_r_ptr  in  PTR_W  checkpointed read pointer
- r_ptr_out  out  PTR_W  current read pointer, for checkpointing
- free_count  out  PTR_W  registers currently free
- overflow_err  out  1  sticky: a free would exceed NUM_PREGS-NUM_AREGS entries

## Operation
- Storage: ring of NUM_PREGS entries × PREG_W; r_ptr, w_ptr PTR_W bits; index = ptr[PREG_W-1:0]; free_count = w_ptr - r_ptr (modulo 2^PTR_W).
- Reset: list[i] = NUM_AREGS+i for i < NUM_PREGS-NUM_AREGS, others 0; r_ptr=0; w_ptr=NUM_PREGS-NUM_AREGS; free_count=96 (defaults); overflow_err=0; alloc_ready=1 while alloc_num ≤ 96.
- Allocate: fire = alloc_valid & alloc_ready & ~restore_valid. On fire r_ptr += alloc_num. All-or-nothing; no partial grants. alloc_ready=0 -> no state change.
- Free: set lanes compacted in ascending lane order; k-th set lane written to list[w_ptr+k]; w_ptr += popcount(free_valid). Frees are never refused.
- Overflow: if free_count + popcount(free_valid) - (fire ? alloc_num : 0) > NUM_PREGS-NUM_AREGS, overflow_err sets and stays set until reset; the write still proceeds (debug only).
- Restore: r_ptr <= restore_r_ptr; same-cycle frees are applied normally; allocation ignored. free_count next = w_ptr_next - restore_r_ptr. Caller guarantees restore_r_ptr lies between the oldest live checkpoint and r_ptr.
- No check for duplicate or reserved IDs in free_preg.

## Timing
- alloc_preg, alloc_ready combinational from current state and alloc_num; pointer/count update on the next edge.
- Freed IDs become allocatable the cycle after the free edge; no free-to-alloc bypass.
- Allocation and free in the same cycle: both applied; free_count next = free_count - alloc_num + popcount(free_valid). alloc_ready uses pre-free count.
- Wrap: pointers wrap modulo 2^PTR_W; index wraps modulo NUM_PREGS; lanes straddling the wrap read/write correct entries.
- Empty (free_count=0): alloc_ready=1 only for alloc_num=0; alloc_preg contents don't-care.
- Reset has priority over restore, alloc and free; reset mid-burst discards all in-flight frees and restores the reset image.
- alloc_num=0 with alloc_valid=1: no-op.

## Test plan
- Reset then alloc_num=2 each cycle ×48 -> grants p32,p33 … p126,p127; free_count 96→0; next request alloc_ready=0, r_ptr unchanged.
- Empty list; free_valid=2'b10, free_preg[1]=p5 -> next cycle free_count=1, alloc_preg[0]=p5; same-cycle alloc of 1 is refused.
- Steady alloc 2 + free 2 for 300 cycles across wrap -> free_count constant at 96, every freed ID re-issued in FIFO order, no overflow_err.
- Capture r_ptr_out=10, alloc 20 more, then restore_valid with restore_r_ptr=10 and a simultaneous free of p3 -> r_ptr=10, p3 appended at old w_ptr, free_count=old count+20+1.
- At free_count=96, free one ID -> overflow_err=1 next cycle and remains 1; drive reset=0 one edge -> overflow_err=0, free_count=96, list reloaded p32..p127.
- reset asserted while alloc_valid and free_valid active -> post-reset state equals reset image; held inputs ignored that edge.

Source files
------------

// File: rtl/superscalar_free_list_if.sv
// Rename / commit / checkpoint side bundle of the physical-register free list.
interface superscalar_free_list_if #(
    parameter int NUM_PREGS = 128,
    parameter int ALLOC_W   = 2,
    parameter int FREE_W    = 2
);
    localparam int PREG_W = $clog2(NUM_PREGS);
    localparam int PTR_W  = PREG_W + 1;
    localparam int NUM_W  = $clog2(ALLOC_W + 1);

    logic                           alloc_valid;
    logic [NUM_W-1:0]               alloc_num;
    logic                           alloc_ready;
    logic [ALLOC_W-1:0][PREG_W-1:0] alloc_preg;
    logic [FREE_W-1:0]              free_valid;
    logic [FREE_W-1:0][PREG_W-1:0]  free_preg;
    logic                           restore_valid;
    logic [PTR_W-1:0]               restore_r_ptr;
    logic [PTR_W-1:0]               r_ptr_out;
    logic [PTR_W-1:0]               free_count;
    logic                           overflow_err;

    modport master (
        output alloc_valid, alloc_num, free_valid, free_preg,
               restore_valid, restore_r_ptr,
        input  alloc_ready, alloc_preg, r_ptr_out, free_count, overflow_err
    );

    modport slave (
        input  alloc_valid, alloc_num, free_valid, free_preg,
               restore_valid, restore_r_ptr,
        output alloc_ready, alloc_preg, r_ptr_out, free_count, overflow_err
    );
endinterface

// File: rtl/superscalar_free_list.sv
// Multi-port physical-register free list. Circular list with wrap-bit pointers;
// rename pops from r_ptr, commit pushes at w_ptr, branch recovery rewinds r_ptr only.
module superscalar_free_list #(
    parameter int NUM_PREGS = 128,
    parameter int NUM_AREGS = 32,
    parameter int ALLOC_W   = 2,
    parameter int FREE_W    = 2
) (
    input logic                     clk,
    input logic                     reset,
    superscalar_free_list_if.slave  bus
);
    localparam int PREG_W    = $clog2(NUM_PREGS);
    localparam int PTR_W     = PREG_W + 1;
    localparam int POP_W     = $clog2(FREE_W + 1);
    localparam int SUM_W     = PTR_W + 1;
    localparam int INIT_FREE = NUM_PREGS - NUM_AREGS;

    logic [PREG_W-1:0] r_list [NUM_PREGS];
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W-1:0]  r_wptr;
    logic              r_ovf;

    logic [PTR_W-1:0]  w_free_count;
    logic              w_ready;
    logic              w_fire;
    logic [POP_W-1:0]  w_pop;
    logic [POP_W-1:0]  w_off [FREE_W];
    logic [PTR_W-1:0]  w_wr_ptr [FREE_W];
    logic [PTR_W-1:0]  w_rd_ptr [ALLOC_W];
    logic [SUM_W-1:0]  w_sum;
    logic              w_ovf;
    logic [PTR_W-1:0]  w_rptr_next;

    assign w_free_count = r_wptr - r_rptr;
    assign w_ready      = w_free_count >= PTR_W'(bus.alloc_num);
    assign w_fire       = bus.alloc_valid & w_ready & ~bus.restore_valid;

    // Compact the set free lanes: each lane's slot is the number of set lanes below it.
    always_comb begin
        w_pop = '0;
        for (int l = 0; l < FREE_W; l++) begin
            w_off[l]    = w_pop;
            w_wr_ptr[l] = r_wptr + PTR_W'(w_pop);
            if (bus.free_valid[l]) w_pop = w_pop + POP_W'(1);
        end
    end

    // Allocation lanes read consecutive entries from r_ptr, wrapping on the index bits.
    always_comb begin
        for (int i = 0; i < ALLOC_W; i++) begin
            w_rd_ptr[i]       = r_rptr + PTR_W'(i);
            bus.alloc_preg[i] = r_list[w_rd_ptr[i][PREG_W-1:0]];
        end
    end

    // Occupancy after this edge, computed one bit wider so an over-free cannot wrap.
    always_comb begin
        w_sum = {1'b0, w_free_count} + SUM_W'(w_pop);
        if (w_fire) w_sum = w_sum - SUM_W'(bus.alloc_num);
        w_ovf = w_sum > SUM_W'(INIT_FREE);
    end

    // Restore wins over allocation; the caller supplies a checkpointed read pointer.
    always_comb begin
        w_rptr_next = r_rptr;
        if (bus.restore_valid)  w_rptr_next = bus.restore_r_ptr;
        else if (w_fire)        w_rptr_next = r_rptr + PTR_W'(bus.alloc_num);
    end

    // State update: reset reloads the identity-after-architectural image.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                r_list[i] <= (i < INIT_FREE) ? PREG_W'(NUM_AREGS + i) : '0;
            end
            r_rptr <= '0;
            r_wptr <= PTR_W'(INIT_FREE);
            r_ovf  <= 1'b0;
        end else begin
            for (int l = 0; l < FREE_W; l++) begin
                if (bus.free_valid[l]) r_list[w_wr_ptr[l][PREG_W-1:0]] <= bus.free_preg[l];
            end
            r_wptr <= r_wptr + PTR_W'(w_pop);
            r_rptr <= w_rptr_next;
            if (w_ovf) r_ovf <= 1'b1;
        end
    end

    assign bus.alloc_ready  = w_ready;
    assign bus.r_ptr_out    = r_rptr;
    assign bus.free_count   = w_free_count;
    assign bus.overflow_err = r_ovf;
endmodule
